// File: rtl/muldiv_iter_unit_pkg.sv
// muldiv_iter_unit_pkg: shared op codes, state encodings and special-case results for the iterative M unit
package muldiv_iter_unit_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam logic [3:0] OP_MUL    = 4'd0;
   localparam logic [3:0] OP_MULH   = 4'd1;
   localparam logic [3:0] OP_MULHSU = 4'd2;
   localparam logic [3:0] OP_MULHU  = 4'd3;
   localparam logic [3:0] OP_DIV    = 4'd4;
   localparam logic [3:0] OP_DIVU   = 4'd5;
   localparam logic [3:0] OP_REM    = 4'd6;
   localparam logic [3:0] OP_REMU   = 4'd7;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = '1;
   localparam logic [XLEN_DEFAULT-1:0] OVF_Q = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
   localparam logic [XLEN_DEFAULT-1:0] OVF_R = '0;
   function automatic logic signed_a(input logic [3:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction
   function automatic logic signed_b(input logic [3:0] op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction
   function automatic logic is_div(input logic [3:0] op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction
   function automatic logic is_rem(input logic [3:0] op);
      return op inside {OP_REM, OP_REMU};
   endfunction
   function automatic logic is_mulh(input logic [3:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction
endpackage

// File: rtl/muldiv_iter_unit_if.sv
// muldiv_iter_unit_if: request/result/stall bundle between the pipeline and the M unit
interface muldiv_iter_unit_if #(parameter int XLEN = muldiv_iter_unit_pkg::XLEN_DEFAULT);
   logic start;
   logic [3:0] op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [4:0] rd_in;
   logic kill;
   logic busy;
   logic stall;
   logic result_valid;
   logic [XLEN-1:0] result;
   logic [4:0] result_rd;
   modport master (output start, op, rs1_val, rs2_val, rd_in, kill,
                   input busy, stall, result_valid, result, result_rd);
   modport slave (input start, op, rs1_val, rs2_val, rd_in, kill,
                  output busy, stall, result_valid, result, result_rd);
endinterface

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: fixed-latency radix-2 shift-add multiplier / restoring divider for RV32M
module muldiv_iter_unit
   import muldiv_iter_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int CNT_W = 6
) (
   input logic clk,
   input logic reset,
   muldiv_iter_unit_if.slave bus
);
   logic [1:0] state;
   logic [CNT_W-1:0] cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0] opb;
   logic [XLEN-1:0] a_raw;
   logic [3:0] op_q;
   logic [4:0] rd_q;
   logic neg_q;
   logic neg_r;
   logic dz;
   logic ovf;
   logic sa;
   logic sb;
   logic accept;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic [XLEN:0] mul_sum;
   logic [2*XLEN:0] sh;
   logic [XLEN:0] diff;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] res_sel;
   // operand conditioning, one iteration step, and final sign fix / result select
   always_comb begin
      sa = signed_a(bus.op) & bus.rs1_val[XLEN-1];
      sb = signed_b(bus.op) & bus.rs2_val[XLEN-1];
      abs_a = sa ? -bus.rs1_val : bus.rs1_val;
      abs_b = sb ? -bus.rs2_val : bus.rs2_val;
      accept = bus.start & ~bus.op[3] & ~bus.kill & (state == S_IDLE);
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      sh = {acc, 1'b0};
      diff = sh[2*XLEN:XLEN] - {1'b0, opb};
      acc_step = is_div(op_q) ? (diff[XLEN] ? sh[2*XLEN-1:0] : {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1})
                              : {mul_sum, acc[XLEN-1:1]};
      prod = neg_q ? -acc : acc;
      quo = dz ? DIV_ZERO_Q : ovf ? OVF_Q : neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem = dz ? a_raw : ovf ? OVF_R : neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      res_sel = is_div(op_q) ? (is_rem(op_q) ? rem : quo)
                             : is_mulh(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      bus.busy = state != S_IDLE;
      bus.stall = (bus.start & (state == S_IDLE) & ~bus.op[3]) | bus.busy;
   end
   // IDLE -> BUSY (XLEN steps) -> FIX -> IDLE; kill or reset abandons the operation
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         acc <= '0;
         opb <= '0;
         a_raw <= '0;
         op_q <= '0;
         rd_q <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz <= 1'b0;
         ovf <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.result <= '0;
         bus.result_rd <= '0;
      end else if (bus.kill) begin
         state <= S_IDLE;
         cnt <= '0;
         bus.result_valid <= 1'b0;
      end else begin
         bus.result_valid <= 1'b0;
         if (accept) begin
            state <= S_BUSY;
            cnt <= '0;
            acc <= {{XLEN{1'b0}}, abs_a};
            opb <= abs_b;
            a_raw <= bus.rs1_val;
            op_q <= bus.op;
            rd_q <= bus.rd_in;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz <= is_div(bus.op) & (bus.rs2_val == '0);
            ovf <= is_div(bus.op) & signed_a(bus.op) & (bus.rs1_val == OVF_Q) & (bus.rs2_val == '1);
         end else if (state == S_BUSY) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
         end else if (state == S_FIX) begin
            bus.result <= res_sel;
            bus.result_rd <= rd_q;
            bus.result_valid <= 1'b1;
            state <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb_muldiv_iter_unit: directed checks of arithmetic, latency, abort and occupancy behaviour
module tb_muldiv_iter_unit;
   import muldiv_iter_unit_pkg::*;
   logic clk = 1'b0;
   logic reset;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   muldiv_iter_unit_if bus ();
   muldiv_iter_unit dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic pre_stall);
      bus.start = 1'b1;
      bus.op = op;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.rd_in = rd;
      #1;
      pre_stall = bus.stall;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_result(output logic [31:0] res, output logic [4:0] rd, output int lat,
                              output int stall_hi);
      lat = 0;
      stall_hi = 0;
      while (bus.result_valid !== 1'b1 && lat < 40) begin
         stall_hi += (bus.stall === 1'b1) ? 1 : 0;
         step();
         lat++;
      end
      res = bus.result;
      rd = bus.result_rd;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      total++;
      if ({bus.busy, bus.stall, bus.result_valid} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.stall, bus.result_valid});
      end
      total++;
      if (bus.result !== 32'h0 || bus.result_rd !== 5'd0) begin
         bad++;
         $display("FAIL reset_result got=%h/%0d exp=0/0", bus.result, bus.result_rd);
      end
   endtask

   task automatic test_mul();
      logic ps;
      logic [31:0] res;
      logic [4:0] rd;
      int lat, sh;
      launch(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd3, ps);
      wait_result(res, rd, lat, sh);
      total++;
      if (res !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
      total++;
      if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      total++;
      if (ps !== 1'b1 || sh !== 33) begin bad++; $display("FAIL mul_stall got=%b/%0d exp=1/33", ps, sh); end
      total++;
      if (rd !== 5'd3 || bus.stall !== 1'b0) begin bad++; $display("FAIL mul_rd_stall got=%0d/%b exp=3/0", rd, bus.stall); end
      step();
      total++;
      if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL mul_pulse got=%b exp=0", bus.result_valid); end
   endtask

   task automatic test_high();
      logic [3:0] ops[3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
      logic [31:0] as[3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] bs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] ex[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
      logic ps;
      logic [31:0] res;
      logic [4:0] rd;
      int lat, sh;
      for (int i = 0; i < 3; i++) begin
         launch(ops[i], as[i], bs[i], 5'(i + 1), ps);
         wait_result(res, rd, lat, sh);
         total++;
         if (res !== ex[i] || lat !== 33) begin
            bad++;
            $display("FAIL high_%0d got=%h lat=%0d exp=%h lat=33", i, res, lat, ex[i]);
         end
      end
   endtask

   task automatic test_div();
      logic [3:0] ops[4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
      logic [31:0] as[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7};
      logic [31:0] bs[4] = '{32'd2, 32'd2, 32'd0, 32'd0};
      logic [31:0] ex[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
      logic ps;
      logic [31:0] res;
      logic [4:0] rd;
      int lat, sh;
      for (int i = 0; i < 4; i++) begin
         launch(ops[i], as[i], bs[i], 5'(i + 20), ps);
         wait_result(res, rd, lat, sh);
         total++;
         if (res !== ex[i] || lat !== 33 || rd !== 5'(i + 20)) begin
            bad++;
            $display("FAIL div_%0d got=%h lat=%0d rd=%0d exp=%h lat=33 rd=%0d", i, res, lat, rd, ex[i], i + 20);
         end
      end
   endtask

   task automatic test_overflow();
      logic [3:0] ops[2] = '{OP_DIV, OP_REM};
      logic [31:0] ex[2] = '{32'h80000000, 32'h0};
      logic ps;
      logic [31:0] res;
      logic [4:0] rd;
      int lat, sh;
      for (int i = 0; i < 2; i++) begin
         launch(ops[i], 32'h80000000, 32'hFFFFFFFF, 5'd12, ps);
         wait_result(res, rd, lat, sh);
         total++;
         if (res !== ex[i] || rd !== 5'd12) begin
            bad++;
            $display("FAIL ovf_%0d got=%h rd=%0d exp=%h rd=12", i, res, rd, ex[i]);
         end
      end
   endtask

   task automatic test_kill();
      logic ps;
      logic [31:0] res;
      logic [4:0] rd;
      int lat, sh, seen;
      launch(OP_MUL, 32'd6, 32'd7, 5'd7, ps);
      wait_result(res, rd, lat, sh);
      total++;
      if (res !== 32'd42) begin bad++; $display("FAIL kill_setup got=%h exp=0000002a", res); end
      launch(OP_DIV, 32'd100, 32'd7, 5'd9, ps);
      repeat (10) step();
      bus.kill = 1'b1;
      step();
      bus.kill = 1'b0;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill_busy got=%b exp=0", bus.busy); end
      seen = 0;
      repeat (40) begin seen += bus.result_valid ? 1 : 0; step(); end
      total++;
      if (seen !== 0 || bus.result !== 32'd42 || bus.result_rd !== 5'd7) begin
         bad++;
         $display("FAIL kill_result got=%0d/%h/%0d exp=0/0000002a/7", seen, bus.result, bus.result_rd);
      end
   endtask

   task automatic test_start_kill();
      bus.start = 1'b1;
      bus.op = OP_DIV;
      bus.rs1_val = 32'd9;
      bus.rs2_val = 32'd3;
      bus.kill = 1'b1;
      step();
      bus.start = 1'b0;
      bus.kill = 1'b0;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_kill got=%b exp=0", bus.busy); end
   endtask

   task automatic test_op3();
      bus.start = 1'b1;
      bus.op = 4'd8;
      #1;
      total++;
      if (bus.stall !== 1'b0) begin bad++; $display("FAIL op3_stall got=%b exp=0", bus.stall); end
      step();
      bus.start = 1'b0;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL op3_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_kill_fix();
      logic ps;
      int seen;
      launch(OP_MUL, 32'd3, 32'd3, 5'd15, ps);
      repeat (32) step();
      bus.kill = 1'b1;
      step();
      bus.kill = 1'b0;
      seen = 0;
      repeat (3) begin seen += bus.result_valid ? 1 : 0; step(); end
      total++;
      if (seen !== 0 || bus.busy !== 1'b0 || bus.result !== 32'd42) begin
         bad++;
         $display("FAIL kill_fix got=%0d/%b/%h exp=0/0/0000002a", seen, bus.busy, bus.result);
      end
   endtask

   task automatic test_ignore();
      logic ps;
      logic [31:0] res;
      logic [4:0] rd;
      int lat, sh;
      launch(OP_MUL, 32'd7, 32'd3, 5'd4, ps);
      bus.start = 1'b1;
      bus.op = OP_DIVU;
      bus.rs1_val = 32'd100;
      bus.rs2_val = 32'd3;
      bus.rd_in = 5'd9;
      repeat (5) step();
      bus.start = 1'b0;
      wait_result(res, rd, lat, sh);
      total++;
      if (res !== 32'd21 || rd !== 5'd4 || lat + 5 !== 33) begin
         bad++;
         $display("FAIL ignore got=%h rd=%0d lat=%0d exp=00000015 rd=4 lat=33", res, rd, lat + 5);
      end
   endtask

   task automatic test_back_to_back();
      logic ps;
      logic [31:0] res;
      logic [4:0] rd;
      int lat, sh;
      launch(OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd5, ps);
      wait_result(res, rd, lat, sh);
      total++;
      if (res !== 32'd1 || rd !== 5'd5) begin bad++; $display("FAIL b2b_first got=%h rd=%0d exp=00000001 rd=5", res, rd); end
      launch(OP_DIVU, 32'd100, 32'd7, 5'd6, ps);
      wait_result(res, rd, lat, sh);
      total++;
      if (ps !== 1'b1 || res !== 32'd14 || rd !== 5'd6 || lat !== 33) begin
         bad++;
         $display("FAIL b2b_second got=%b/%h/%0d/%0d exp=1/0000000e/6/33", ps, res, rd, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic ps;
      int seen;
      launch(OP_MUL, 32'd5, 32'd5, 5'd2, ps);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if ({bus.busy, bus.result_valid} !== 2'b00 || bus.result !== 32'h0 || bus.result_rd !== 5'd0) begin
         bad++;
         $display("FAIL reset_mid got=%b%b/%h/%0d exp=00/0/0", bus.busy, bus.result_valid, bus.result, bus.result_rd);
      end
      seen = 0;
      repeat (40) begin seen += bus.result_valid ? 1 : 0; step(); end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL reset_mid_valid got=%0d exp=0", seen); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op = 4'd0;
      bus.rs1_val = '0;
      bus.rs2_val = '0;
      bus.rd_in = '0;
      bus.kill = 1'b0;
      reset = 1'b1;
      test_reset();
      test_mul();
      test_high();
      test_div();
      test_overflow();
      test_kill();
      test_start_kill();
      test_op3();
      test_kill_fix();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
